// File: rtl/stoch_norm_decoder.sv
// Stochastic bitstream to binary count decoder: settle interval, back-to-back windows,
// single-entry valid/ready result register. Define STOCH_NORM_DECODER_BIPOLAR_EN for a signed result.
module stoch_norm_decoder #(
  parameter int WINDOW_LOG2   = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int SETTLE_WIDTH  = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 en,
  input  logic                 a,
  output logic                 busy,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [WINDOW_LOG2:0] y_count,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    ACCUM
  } state_e;

  localparam logic [WINDOW_LOG2-1:0]  CNT_LAST    = '1;
  localparam logic [SETTLE_WIDTH-1:0] SETTLE_LAST = SETTLE_WIDTH'(SETTLE_CYCLES - 1);
  localparam int                      HALF_INT    = 1 << (WINDOW_LOG2 - 1);
  localparam logic [WINDOW_LOG2:0]    HALF        = HALF_INT[WINDOW_LOG2:0];

  state_e                  state_q, state_d;
  logic [SETTLE_WIDTH-1:0] settle_cnt_q, settle_cnt_d;
  logic [WINDOW_LOG2-1:0]  samp_cnt_q, samp_cnt_d;
  logic [WINDOW_LOG2:0]    acc_q, acc_d;
  logic                    y_valid_q, y_valid_d;
  logic [WINDOW_LOG2:0]    y_count_q, y_count_d;
  logic                    overrun_q, overrun_d;

  logic                    complete;
  logic [WINDOW_LOG2:0]    result;
  logic [WINDOW_LOG2:0]    load_value;

  assign result = acc_q + {{WINDOW_LOG2{1'b0}}, a};

`ifdef STOCH_NORM_DECODER_BIPOLAR_EN
  assign load_value = result - HALF;
`else
  assign load_value = result;
`endif

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    acc_d        = acc_q;
    complete     = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d      = (SETTLE_CYCLES > 0) ? SETTLE : ACCUM;
          settle_cnt_d = '0;
        end
      end
      SETTLE: begin
        if (!en) begin
          state_d      = IDLE;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = ACCUM;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_WIDTH'(1);
        end
      end
      ACCUM: begin
        if (!en) begin
          state_d    = IDLE;
          acc_d      = '0;
          samp_cnt_d = '0;
        end else if (samp_cnt_q == CNT_LAST) begin
          complete   = 1'b1;
          acc_d      = '0;
          samp_cnt_d = '0;
        end else begin
          acc_d      = result;
          samp_cnt_d = samp_cnt_q + WINDOW_LOG2'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion and consume in the same cycle refill the register without a bubble.
  always_comb begin
    y_valid_d = y_valid_q;
    y_count_d = y_count_q;
    overrun_d = 1'b0;

    if (complete) begin
      if (!y_valid_q || y_ready) begin
        y_valid_d = 1'b1;
        y_count_d = load_value;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every register samples the pre-edge value of the others.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      acc_q        <= '0;
      y_valid_q    <= 1'b0;
      y_count_q    <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      acc_q        <= acc_d;
      y_valid_q    <= y_valid_d;
      y_count_q    <= y_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign y_valid = y_valid_q;
  assign y_count = y_count_q;
  assign overrun = overrun_q;

endmodule
